alu_muldiv_unit: RTL and testbench
==================================

Name: alu_muldiv_unit

Overview:
Parametrised successor to the ALU control/ALU pair. It decodes ALUOp/function into an ALU operation code, executes the operation on WIDTH-bit operands, and adds an iterative unsigned multiply/divide unit with HI/LO registers. Transfers on both sides use a valid/ready handshake, so the datapath stalls on in_ready=0 while a multi-cycle op runs.

Parameters:
WIDTH, 32, operand/result width; even, >= 8
MULDIV_EN, 1, 1 = MULTU/DIVU/MFHI/MFLO implemented; 0 = those codes decode as illegal
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  operation presented
in_ready  out  1  unit can accept an operation this cycle
alu_op  in  3  ALUOp from main control
alu_function  in  6  instruction funct field
operand_a  in  WIDTH  rs value / dividend / multiplicand
operand_b  in  WIDTH  rt or immediate / divisor / multiplier
shamt  in  $clog2(WIDTH)  shift amount
out_valid  out  1  one-cycle pulse, result valid
result  out  WIDTH  registered result
zero  out  1  result == 0, registered with result
illegal  out  1  pulses with out_valid for undecoded selector
alu_operation  out  4  combinational decode of {alu_op, alu_function}

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, zero=1, illegal=0, HI=0, LO=0, state=IDLE, counter=0. Reset mid-operation aborts, discards partial product/quotient, and clears HI/LO.
- Decode (alu_operation codes): AND=0000, OR=0001, NOR=0010, ADD=0011, SUB=0100, LUI=0101, SLL=0110, SRL=0111, MULTU=1010, DIVU=1011, MFHI=1100, MFLO=1101, illegal=1001.
- R-type decode: alu_op=111 with funct 100100 AND, 100101 OR, 100111 NOR, 100000 ADD, 100010 SUB, 000000 SLL, 000010 SRL, 011001 MULTU, 011011 DIVU, 010000 MFHI, 010010 MFLO.
- I-type decode: alu_op 000 ANDI, 001 ORI, 100 ADDI, 101 LUI; funct ignored.
- Accept: an operation is accepted when in_valid && in_ready.
- States:
  - IDLE: in_ready=1.
  - Single-cycle op: result, zero and illegal registered; out_valid=1 the next cycle (latency 1); stay IDLE. Back-to-back accepts give one result per cycle.
  - MULTU accepted -> MUL: shift-add, one multiplier bit per cycle, WIDTH iterations. Last cycle writes {HI,LO}=a*b (2*WIDTH bits) and returns to IDLE. out_valid pulses with result=0. Accept-to-out_valid latency is WIDTH cycles.
  - DIVU accepted -> DIV: restoring division, WIDTH iterations, same latency. LO=quotient, HI=remainder.
  - MUL and DIV: in_ready=0; in_valid ignored.
- Divide by zero: no trap; natural restoring result LO=all ones, HI=operand_a, normal latency.
- Completion overlap: in the cycle out_valid pulses for MUL/DIV the state is IDLE and in_ready=1, so a new op may be accepted that same cycle.
- MFHI/MFLO: result=HI/LO, latency 1. HI/LO hold until the next MULTU/DIVU completes.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH with no overflow flag. NOR = ~(a|b). LUI = operand_b[WIDTH/2-1:0] << WIDTH/2. SLL/SRL shift operand_b by shamt, logical.
- Illegal selector: out_valid=1, illegal=1, result=0, latency 1. With MULDIV_EN=0, MULTU/DIVU/MFHI/MFLO take this path.

Decomposition:
- Package alu_pkg: ALUOp localparams, funct localparams, 4-bit operation-code localparams, FSM state enum (IDLE, MUL, DIV).
- Sub-module alu_op_decode: combinational {alu_op, alu_function} -> operation code plus illegal flag. Shared with the single-cycle datapath.
- FSM, HI/LO and the iteration datapath stay in the top module.

Test Plan:
- Reset, then ADD 7+5 (alu_op=111, funct=100000) -> out_valid next cycle, result=12, zero=0, alu_operation=0011.
- Back-to-back SUB 5-5 then LUI b=0x1234 -> result 0 with zero=1, then result 0x12340000 on consecutive cycles.
- MULTU 0xFFFFFFFF*2 -> in_ready low for WIDTH-1 cycles, out_valid after 32 cycles; MFHI=0x00000001, MFLO=0xFFFFFFFE.
- DIVU 100/7 then DIVU 9/0 -> HI=2, LO=14; then HI=9, LO=0xFFFFFFFF.
- Reset asserted mid-MULTU (cycle 10) -> no out_valid, in_ready=1 the next cycle, MFHI/MFLO return 0.
- alu_op=111, funct=111111 -> illegal=1, out_valid=1, result=0, alu_operation=1001; same result for MULTU with MULDIV_EN=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU / multiply-divide unit: ALUOp, funct, operation codes, FSM states.
// Pure declarations, no logic, so there is no latency.
// Pure declarations, so there is no backpressure.
package alu_pkg;

  // ALUOp values from main control
  localparam logic [2:0] ALUOP_ANDI  = 3'b000;
  localparam logic [2:0] ALUOP_ORI   = 3'b001;
  localparam logic [2:0] ALUOP_ADDI  = 3'b100;
  localparam logic [2:0] ALUOP_LUI   = 3'b101;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  // R-type funct field values
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  // 4-bit operation codes presented on alu_operation
  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_NOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_LUI     = 4'b0101;
  localparam logic [3:0] OP_SLL     = 4'b0110;
  localparam logic [3:0] OP_SRL     = 4'b0111;
  localparam logic [3:0] OP_ILLEGAL = 4'b1001;
  localparam logic [3:0] OP_MULTU   = 4'b1010;
  localparam logic [3:0] OP_DIVU    = 4'b1011;
  localparam logic [3:0] OP_MFHI    = 4'b1100;
  localparam logic [3:0] OP_MFLO    = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// Operation/result bundle between the issuing stage and alu_muldiv_unit.
// Wires only; timing is set by the unit behind the slave modport.
// Issue side stalls while in_ready is low; the result side is a one-cycle out_valid pulse with no ready.
interface alu_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [5:0]       alu_function;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [3:0]       alu_operation;

  // Issuing side
  modport master (
    output in_valid, alu_op, alu_function, operand_a, operand_b, shamt,
    input  in_ready, out_valid, result, zero, illegal, alu_operation
  );

  // Execution unit side
  modport slave (
    input  in_valid, alu_op, alu_function, operand_a, operand_b, shamt,
    output in_ready, out_valid, result, zero, illegal, alu_operation
  );
endinterface

// File: rtl/alu_op_decode.sv
// Maps {ALUOp, funct} onto a 4-bit operation code and flags undecoded selectors.
// Purely combinational, zero latency.
// No handshake; the caller qualifies the output with its own valid.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic [2:0] alu_op_i,
  input  logic [5:0] alu_function_i,
  output logic [3:0] op_o,
  output logic       illegal_o
);

  // Selector decode; anything not listed falls through to the illegal code
  always_comb begin
    op_o = OP_ILLEGAL;
    case (alu_op_i)
      ALUOP_ANDI: op_o = OP_AND;
      ALUOP_ORI:  op_o = OP_OR;
      ALUOP_ADDI: op_o = OP_ADD;
      ALUOP_LUI:  op_o = OP_LUI;
      ALUOP_RTYPE: begin
        case (alu_function_i)
          FUNCT_AND:   op_o = OP_AND;
          FUNCT_OR:    op_o = OP_OR;
          FUNCT_NOR:   op_o = OP_NOR;
          FUNCT_ADD:   op_o = OP_ADD;
          FUNCT_SUB:   op_o = OP_SUB;
          FUNCT_SLL:   op_o = OP_SLL;
          FUNCT_SRL:   op_o = OP_SRL;
          FUNCT_MULTU: op_o = MULDIV_EN ? OP_MULTU : OP_ILLEGAL;
          FUNCT_DIVU:  op_o = MULDIV_EN ? OP_DIVU  : OP_ILLEGAL;
          FUNCT_MFHI:  op_o = MULDIV_EN ? OP_MFHI  : OP_ILLEGAL;
          FUNCT_MFLO:  op_o = MULDIV_EN ? OP_MFLO  : OP_ILLEGAL;
          default:     op_o = OP_ILLEGAL;
        endcase
      end
      default: op_o = OP_ILLEGAL;
    endcase
    illegal_o = (op_o == OP_ILLEGAL);
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Single-cycle ALU plus iterative unsigned multiply/divide writing HI/LO.
// Latency 1 for ALU/MFHI/MFLO/illegal; WIDTH cycles for MULTU/DIVU.
// in_ready drops while MULTU/DIVU iterate; it rises again in the completion cycle.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input logic              clk,
  input logic              reset,
  alu_muldiv_unit_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Decoded selector, shared by the ALU datapath and the FSM
  logic [3:0] dec_op;
  logic       dec_illegal;

  alu_op_decode #(
    .MULDIV_EN (MULDIV_EN)
  ) u_dec (
    .alu_op_i       (bus.alu_op),
    .alu_function_i (bus.alu_function),
    .op_o           (dec_op),
    .illegal_o      (dec_illegal)
  );

  // State and datapath registers
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   wk_q, wk_d;       // {upper W+1 bits, lower W bits} shared by MUL and DIV
  logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor held during iteration
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  logic               in_ready;
  logic               accept;
  logic               start_md;
  logic               last_iter;
  logic [WIDTH-1:0]   alu_res;

  logic               step_mul;
  logic [2*WIDTH:0]   step_in;
  logic [WIDTH-1:0]   step_opb;
  logic [2*WIDTH:0]   step_out;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;

  // FSM next state, ready and accept qualification
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    start_md  = 1'b0;
    last_iter = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
        if (bus.in_valid && (dec_op == OP_MULTU)) begin
          state_d  = MUL;
          start_md = 1'b1;
        end else if (bus.in_valid && (dec_op == OP_DIVU)) begin
          state_d  = DIV;
          start_md = 1'b1;
        end
      end
      MUL, DIV: begin
        if (cnt_q == LAST_CNT) begin
          last_iter = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ALU result; illegal selectors produce zero
  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_AND:  alu_res = bus.operand_a & bus.operand_b;
      OP_OR:   alu_res = bus.operand_a | bus.operand_b;
      OP_NOR:  alu_res = ~(bus.operand_a | bus.operand_b);
      OP_ADD:  alu_res = bus.operand_a + bus.operand_b;
      OP_SUB:  alu_res = bus.operand_a - bus.operand_b;
      OP_LUI:  alu_res = {bus.operand_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  alu_res = bus.operand_b << bus.shamt;
      OP_SRL:  alu_res = bus.operand_b >> bus.shamt;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // One multiply/divide iteration; the accept cycle runs the first one straight from the operands
  always_comb begin
    if (state_q == IDLE) begin
      step_mul = (dec_op == OP_MULTU);
      step_in  = step_mul ? {{(WIDTH+1){1'b0}}, bus.operand_b}
                          : {{(WIDTH+1){1'b0}}, bus.operand_a};
      step_opb = step_mul ? bus.operand_a : bus.operand_b;
    end else begin
      step_mul = (state_q == MUL);
      step_in  = wk_q;
      step_opb = opb_q;
    end
    // Shift-add: conditionally add multiplicand to the upper half, then shift the pair right
    mul_sum  = step_in[2*WIDTH:WIDTH] + (step_in[0] ? {1'b0, step_opb} : {(WIDTH+1){1'b0}});
    // Restoring divide: remainder stays below 2^WIDTH, so its top bit can be dropped before shifting
    div_sh   = {step_in[2*WIDTH-1:WIDTH], step_in[WIDTH-1]};
    div_diff = div_sh - {1'b0, step_opb};
    if (step_mul) begin
      step_out = {1'b0, mul_sum, step_in[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      step_out = {div_diff, step_in[WIDTH-2:0], 1'b1};
    end else begin
      step_out = {div_sh, step_in[WIDTH-2:0], 1'b0};
    end
  end

  // Datapath next state: result registers, iteration registers, HI/LO
  always_comb begin
    cnt_d       = cnt_q;
    wk_d        = wk_q;
    opb_d       = opb_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = 1'b0;
    if (start_md) begin
      wk_d  = step_out;
      opb_d = step_opb;
      cnt_d = CNT_W'(1);
    end else if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      illegal_d   = dec_illegal;
    end else if (state_q != IDLE) begin
      wk_d  = step_out;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) begin
        hi_d        = step_out[2*WIDTH-1:WIDTH];
        lo_d        = step_out[WIDTH-1:0];
        cnt_d       = '0;
        out_valid_d = 1'b1;
        result_d    = '0;
        zero_d      = 1'b1;
      end
    end
  end

  // State register; reset abandons any in-flight iteration and clears HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wk_q        <= '0;
      opb_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wk_q        <= wk_d;
      opb_q       <= opb_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.result        = result_q;
  assign bus.zero          = zero_q;
  assign bus.illegal       = illegal_q;
  assign bus.alu_operation = dec_op;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Scoreboard bench: stimulus pushes expected responses, monitors pop them on out_valid.
// Covers ALU ops, MULTU/DIVU with HI/LO, divide by zero, reset mid-multiply, illegal selectors.
// A second instance with MULDIV_EN=0 checks that multiply/divide codes decode as illegal.
module tb_alu_muldiv_unit;

  logic clk;
  logic reset;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];

  alu_muldiv_unit_if #(.WIDTH(32)) bus ();
  alu_muldiv_unit_if #(.WIDTH(32)) bus0 ();

  alu_muldiv_unit #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_muldiv_unit #(.WIDTH(32), .MULDIV_EN(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Scoreboard monitor for the MULDIV_EN=1 instance
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, " result"}, bus.result, e.res);
        chk({e.name, " zero"}, {31'd0, bus.zero}, {31'd0, (e.res == 32'd0)});
        chk({e.name, " illegal"}, {31'd0, bus.illegal}, {31'd0, e.ill});
        chk({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  // Scoreboard monitor for the MULDIV_EN=0 instance
  always @(negedge clk) begin
    if (bus0.out_valid === 1'b1) begin
      if (q0.size() == 0) begin
        chk("dut0 unexpected out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk({e.name, " result"}, bus0.result, e.res);
        chk({e.name, " zero"}, {31'd0, bus0.zero}, {31'd0, (e.res == 32'd0)});
        chk({e.name, " illegal"}, {31'd0, bus0.illegal}, {31'd0, e.ill});
        chk({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  // Present one op to the main instance, wait for acceptance, optionally push the expected response.
  // Called just after a rising edge.
  task automatic issue(input string nm, input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [3:0] exp_op, input bit push, input logic [31:0] res,
                       input logic ill, input int lat);
    int n;
    exp_t e;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk({nm, " in_ready timeout"}, 32'd0, 32'd1);
    bus.in_valid     = 1'b1;
    bus.alu_op       = op;
    bus.alu_function = fn;
    bus.operand_a    = a;
    bus.operand_b    = b;
    bus.shamt        = sh;
    #1;
    chk({nm, " alu_operation"}, {28'd0, bus.alu_operation}, {28'd0, exp_op});
    @(posedge clk);
    #1;
    if (push) begin
      e.name = nm; e.res = res; e.ill = ill; e.lat = lat; e.acc = cyc;
      q.push_back(e);
    end
    bus.in_valid = 1'b0;
  endtask

  // Count cycles with in_ready low, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_op;
    logic [31:0] res;
    logic        ill;
  } vec0_t;

  initial begin
    int    busy;
    int    n;
    vec0_t v0[3];

    cyc = 0; pass_cnt = 0; total_cnt = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.alu_op = 3'b000; bus.alu_function = 6'd0;
    bus.operand_a = '0; bus.operand_b = '0; bus.shamt = '0;
    bus0.in_valid = 1'b0; bus0.alu_op = 3'b000; bus0.alu_function = 6'd0;
    bus0.operand_a = '0; bus0.operand_b = '0; bus0.shamt = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset zero", {31'd0, bus.zero}, 32'd1);
    chk("reset illegal", {31'd0, bus.illegal}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single-cycle ALU ops, back-to-back
    issue("ADD 7+5",    3'b111, 6'b100000, 32'd7,        32'd5,        5'd0,  4'b0011, 1, 32'd12,        0, 1);
    issue("SUB 5-5",    3'b111, 6'b100010, 32'd5,        32'd5,        5'd0,  4'b0100, 1, 32'd0,         0, 1);
    issue("LUI 0x1234", 3'b101, 6'b000000, 32'd0,        32'h00001234, 5'd0,  4'b0101, 1, 32'h12340000,  0, 1);
    issue("ANDI",       3'b000, 6'b111111, 32'h0000F0F0, 32'h0000FF00, 5'd0,  4'b0000, 1, 32'h0000F000,  0, 1);
    issue("ORI",        3'b001, 6'b000000, 32'h0000F0F0, 32'h00000F0F, 5'd0,  4'b0001, 1, 32'h0000FFFF,  0, 1);
    issue("NOR 0,0",    3'b111, 6'b100111, 32'd0,        32'd0,        5'd0,  4'b0010, 1, 32'hFFFFFFFF,  0, 1);
    issue("SLL 1<<31",  3'b111, 6'b000000, 32'hDEADBEEF, 32'd1,        5'd31, 4'b0110, 1, 32'h80000000,  0, 1);
    issue("SRL >>31",   3'b111, 6'b000010, 32'd0,        32'h80000000, 5'd31, 4'b0111, 1, 32'd1,         0, 1);
    issue("ADDI wrap",  3'b100, 6'b000000, 32'hFFFFFFFF, 32'd1,        5'd0,  4'b0011, 1, 32'd0,         0, 1);

    // MULTU, then HI/LO readback issued in the completion cycle
    issue("MULTU", 3'b111, 6'b011001, 32'hFFFFFFFF, 32'd2, 5'd0, 4'b1010, 1, 32'd0, 0, 32);
    count_busy(busy);
    chk("MULTU in_ready low cycles", 32'(busy), 32'd31);
    issue("MFHI after MULTU", 3'b111, 6'b010000, 32'd0, 32'd0, 5'd0, 4'b1100, 1, 32'd1,        0, 1);
    issue("MFLO after MULTU", 3'b111, 6'b010010, 32'd0, 32'd0, 5'd0, 4'b1101, 1, 32'hFFFFFFFE, 0, 1);

    // DIVU, including divide by zero
    issue("DIVU 100/7", 3'b111, 6'b011011, 32'd100, 32'd7, 5'd0, 4'b1011, 1, 32'd0, 0, 32);
    issue("MFHI 100/7", 3'b111, 6'b010000, 32'd0,   32'd0, 5'd0, 4'b1100, 1, 32'd2,  0, 1);
    issue("MFLO 100/7", 3'b111, 6'b010010, 32'd0,   32'd0, 5'd0, 4'b1101, 1, 32'd14, 0, 1);
    issue("DIVU 9/0",   3'b111, 6'b011011, 32'd9,   32'd0, 5'd0, 4'b1011, 1, 32'd0, 0, 32);
    issue("MFHI 9/0",   3'b111, 6'b010000, 32'd0,   32'd0, 5'd0, 4'b1100, 1, 32'd9,        0, 1);
    issue("MFLO 9/0",   3'b111, 6'b010010, 32'd0,   32'd0, 5'd0, 4'b1101, 1, 32'hFFFFFFFF, 0, 1);

    // Reset in the middle of a MULTU: no completion, HI/LO cleared
    issue("MULTU aborted", 3'b111, 6'b011001, 32'd3, 32'd4, 5'd0, 4'b1010, 0, 32'd0, 0, 32);
    repeat (9) @(posedge clk);
    #1;
    chk("mid-MULTU in_ready", {31'd0, bus.in_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post-abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post-abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    issue("MFHI after abort", 3'b111, 6'b010000, 32'd0, 32'd0, 5'd0, 4'b1100, 1, 32'd0, 0, 1);
    issue("MFLO after abort", 3'b111, 6'b010010, 32'd0, 32'd0, 5'd0, 4'b1101, 1, 32'd0, 0, 1);

    // Illegal selectors
    issue("illegal funct",  3'b111, 6'b111111, 32'd1, 32'd2, 5'd0, 4'b1001, 1, 32'd0, 1, 1);
    issue("illegal alu_op", 3'b010, 6'b100000, 32'd1, 32'd2, 5'd0, 4'b1001, 1, 32'd0, 1, 1);

    // MULDIV_EN=0 instance: multiply/divide codes take the illegal path
    v0[0] = '{"dut0 MULTU", 6'b011001, 32'hFFFFFFFF, 32'd2, 4'b1001, 32'd0, 1'b1};
    v0[1] = '{"dut0 MFHI",  6'b010000, 32'd0,        32'd0, 4'b1001, 32'd0, 1'b1};
    v0[2] = '{"dut0 ADD",   6'b100000, 32'd1,        32'd1, 4'b0011, 32'd2, 1'b0};
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      bus0.in_valid     = 1'b1;
      bus0.alu_op       = 3'b111;
      bus0.alu_function = v0[i].fn;
      bus0.operand_a    = v0[i].a;
      bus0.operand_b    = v0[i].b;
      #1;
      chk({v0[i].name, " alu_operation"}, {28'd0, bus0.alu_operation}, {28'd0, v0[i].exp_op});
      chk({v0[i].name, " in_ready"}, {31'd0, bus0.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      e.name = v0[i].name; e.res = v0[i].res; e.ill = v0[i].ill; e.lat = 1; e.acc = cyc;
      q0.push_back(e);
      bus0.in_valid = 1'b0;
    end

    // Drain and make sure nothing extra appears
    n = 0;
    while ((q.size() != 0 || q0.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard drained", 32'(q.size() + q0.size()), 32'd0);
    repeat (40) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
